// File: rtl/stream_seq_ctrl_if.sv
// Handshake bundle between the streaming-kernel sequencer and its environment.
// The master side drives run control and flow control; the slave side is the sequencer.
interface stream_seq_ctrl_if #(
    parameter int unsigned AW = 6,
    parameter int unsigned CW = 32
) ();
    logic          start;
    logic          abort;
    logic          src_valid;
    logic          dst_ready;
    logic          stall;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic [CW-1:0] stall_cnt;

    modport master (
        output start, abort, src_valid, dst_ready,
        input  stall, rd_en, rd_addr, wr_en, wr_addr, busy, done, stall_cnt
    );

    modport slave (
        input  start, abort, src_valid, dst_ready,
        output stall, rd_en, rd_addr, wr_en, wr_addr, busy, done, stall_cnt
    );
endinterface

// File: rtl/stream_seq_ctrl.sv
// Stall-safe sequencer for a fixed-latency streaming kernel: issues read addresses,
// tracks in-flight items through LAT advancing cycles and issues aligned write addresses.
module stream_seq_ctrl #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned LAT  = 5,
    parameter int unsigned AW   = 6,
    parameter int unsigned CW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e        state_q,     state_d;
    logic [AW-1:0] rd_cnt_q,    rd_cnt_d;
    logic [AW-1:0] wr_cnt_q,    wr_cnt_d;
    logic [LAT-1:0] vld_q,      vld_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic           active;
    logic           need_src;
    logic           need_dst;
    logic           adv;
    logic           rd_en;
    logic           wr_en;
    logic [LAT-1:0] vld_shift;

    // vld_q mirrors the kernel pipeline occupancy; bit LAT-1 marks an item at the output.
    generate
        if (LAT == 1) begin : g_lat1
            assign vld_shift = rd_en;
        end else begin : g_latn
            assign vld_shift = {vld_q[LAT-2:0], rd_en};
        end
    endgenerate

    always_comb begin
        active   = (state_q == S_RUN) || (state_q == S_DRAIN);
        need_src = (state_q == S_RUN);
        need_dst = vld_q[LAT-1];
        adv      = active && (!need_src || bus.src_valid) && (!need_dst || bus.dst_ready);
        rd_en    = adv && need_src;
        wr_en    = adv && need_dst;
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        vld_d       = vld_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d     = S_RUN;
                    rd_cnt_d    = '0;
                    wr_cnt_d    = '0;
                    vld_d       = '0;
                    stall_cnt_d = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (!adv && (stall_cnt_q != '1)) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
                if (adv) begin
                    vld_d    = vld_shift;
                    rd_cnt_d = rd_cnt_q + AW'(rd_en);
                    wr_cnt_d = wr_cnt_q + AW'(wr_en);
                    if (rd_en && (rd_cnt_q == AW'(SIZE - 1))) begin
                        state_d = S_DRAIN;
                    end
                    if (wr_en && (wr_cnt_q == AW'(SIZE - 1))) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort keeps stall_cnt so the aborted run's stall figure stays visible.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            vld_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            vld_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = !adv;
    assign bus.rd_en     = rd_en;
    assign bus.wr_en     = wr_en;
    assign bus.rd_addr   = rd_cnt_q;
    assign bus.wr_addr   = wr_cnt_q;
    assign bus.busy      = active;
    assign bus.done      = (state_q == S_DONE);
    assign bus.stall_cnt = stall_cnt_q;

endmodule
